// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- hazard, stall, flush and halt controller for a 5-stage pipeline.
//
// Build option: define PIPE_CTRL_FORWARD_EN when the datapath forwards from
// EX/MEM and MEM/WB. Then only load-use hazards stall. Without it, any RAW
// dependency on the ID/EX or EX/MEM destination stalls.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   id_rs, id_rt           source registers of the instruction in ID
//   id_rs_vld, id_rt_vld   the source register is actually read
//   idex_reg_write         ID/EX writes a register
//   idex_mem_read          ID/EX is a load
//   idex_write_reg         ID/EX destination
//   exmem_reg_write        EX/MEM writes a register
//   exmem_write_reg        EX/MEM destination
//   exmem_halt             halt instruction has reached MEM
//   mem_redirect           taken branch / jump resolved in MEM
//   imem_stall, dmem_stall instruction / data memory not done this cycle
//   pc_write, ifid_write   PC and IF/ID load enables
//   ifid_flush, idex_flush, exmem_flush  load a bubble into that register
//   freeze                 every pipeline register holds its value
//   halted                 processor stopped (sticky until rst)
//   stall_cycles           count of non-advancing cycles (wraps)
//   err                    watchdog error, sticky until rst
//
// Handshake: the memories report "not done" by holding imem_stall/dmem_stall
// high for as many cycles as they need; the controller samples them every
// cycle and never waits on any other acknowledgement.
// ---------------------------------------------------------------------------
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_vld,
    input  logic        id_rt_vld,
    input  logic        idex_reg_write,
    input  logic        idex_mem_read,
    input  logic [2:0]  idex_write_reg,
    input  logic        exmem_reg_write,
    input  logic [2:0]  exmem_write_reg,
    input  logic        exmem_halt,
    input  logic        mem_redirect,
    input  logic        imem_stall,
    input  logic        dmem_stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        freeze,
    output logic        halted,
    output logic [15:0] stall_cycles,
    output logic        err
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DSTALL = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    // Watchdog fires after this many consecutive frozen cycles.
    localparam logic [6:0] WD_LIMIT = 7'd64;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [6:0] wd_cnt;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    logic ex_qual;
    logic mem_qual;
    logic hazard;

`ifdef PIPE_CTRL_FORWARD_EN
    // Forwarding covers everything except a load whose data is not yet read.
    assign ex_qual  = idex_reg_write & idex_mem_read;
    assign mem_qual = 1'b0;
    logic unused_exmem;
    assign unused_exmem = ^{exmem_reg_write, exmem_write_reg};
`else
    assign ex_qual  = idex_reg_write;
    assign mem_qual = exmem_reg_write;
`endif

    // MEM/WB is not checked: the register file writes in the first half-cycle.
    assign hazard =
        (id_rs_vld & ((ex_qual  & (id_rs == idex_write_reg)) |
                      (mem_qual & (id_rs == exmem_write_reg)))) |
        (id_rt_vld & ((ex_qual  & (id_rt == idex_write_reg)) |
                      (mem_qual & (id_rt == exmem_write_reg))));

    // -----------------------------------------------------------------------
    // Priority rules applied whenever the pipeline is not frozen (RUN, or the
    // release cycle of DSTALL). A redirect that arrived during a data stall
    // is still sitting in the frozen EX/MEM register, so it is honoured here.
    // -----------------------------------------------------------------------
    logic bf_pc_write;
    logic bf_ifid_write;
    logic bf_ifid_flush;
    logic bf_idex_flush;
    logic bf_exmem_flush;
    logic bf_halt;

    always_comb begin
        bf_pc_write    = 1'b0;
        bf_ifid_write  = 1'b0;
        bf_ifid_flush  = 1'b0;
        bf_idex_flush  = 1'b0;
        bf_exmem_flush = 1'b0;
        bf_halt        = 1'b0;
        if (mem_redirect) begin
            bf_pc_write    = 1'b1;
            bf_ifid_flush  = 1'b1;
            bf_idex_flush  = 1'b1;
            bf_exmem_flush = 1'b1;
        end else if (exmem_halt) begin
            bf_ifid_flush = 1'b1;
            bf_idex_flush = 1'b1;
            bf_halt       = 1'b1;
        end else if (hazard) begin
            bf_idex_flush = 1'b1;
        end else if (imem_stall) begin
            bf_ifid_flush = 1'b1;
        end else begin
            bf_pc_write   = 1'b1;
            bf_ifid_write = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // FSM outputs and next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        freeze      = 1'b0;
        if (rst) begin
            // Fill the pipe with bubbles while reset is held.
            state_next  = ST_RUN;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (state)
                ST_RUN, ST_DSTALL: begin
                    if (dmem_stall) begin
                        freeze     = 1'b1;
                        state_next = ST_DSTALL;
                    end else begin
                        pc_write    = bf_pc_write;
                        ifid_write  = bf_ifid_write;
                        ifid_flush  = bf_ifid_flush;
                        idex_flush  = bf_idex_flush;
                        exmem_flush = bf_exmem_flush;
                        state_next  = bf_halt ? ST_HALT : ST_RUN;
                    end
                end
                ST_HALT: begin
                    // Front end held empty; EX/MEM and MEM/WB drain normally.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State, sticky flags, stall counter, watchdog
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            halted       <= 1'b0;
            err          <= 1'b0;
            stall_cycles <= 16'd0;
            wd_cnt       <= 7'd0;
        end else begin
            state <= state_next;
            if (state_next == ST_HALT) begin
                halted <= 1'b1;
            end
            if (!pc_write && (state != ST_HALT)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            // Counts consecutive frozen cycles, including the cycle that
            // enters DSTALL; saturates at the limit.
            if (freeze) begin
                if (wd_cnt != WD_LIMIT) begin
                    wd_cnt <= wd_cnt + 7'd1;
                end
                if (wd_cnt == WD_LIMIT - 7'd1) begin
                    err <= 1'b1;
                end
            end else begin
                wd_cnt <= 7'd0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- directed bench for pipe_ctrl. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  id_rs, id_rt;
    logic        id_rs_vld, id_rt_vld;
    logic        idex_reg_write, idex_mem_read;
    logic [2:0]  idex_write_reg;
    logic        exmem_reg_write;
    logic [2:0]  exmem_write_reg;
    logic        exmem_halt, mem_redirect, imem_stall, dmem_stall;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic        freeze, halted, err;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rs_vld       (id_rs_vld),
        .id_rt_vld       (id_rt_vld),
        .idex_reg_write  (idex_reg_write),
        .idex_mem_read   (idex_mem_read),
        .idex_write_reg  (idex_write_reg),
        .exmem_reg_write (exmem_reg_write),
        .exmem_write_reg (exmem_write_reg),
        .exmem_halt      (exmem_halt),
        .mem_redirect    (mem_redirect),
        .imem_stall      (imem_stall),
        .dmem_stall      (dmem_stall),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .freeze          (freeze),
        .halted          (halted),
        .stall_cycles    (stall_cycles),
        .err             (err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock: return at the next falling edge, then settle 1 ns.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 3'd0; id_rt = 3'd0; id_rs_vld = 1'b0; id_rt_vld = 1'b0;
        idex_reg_write = 1'b0; idex_mem_read = 1'b0; idex_write_reg = 3'd0;
        exmem_reg_write = 1'b0; exmem_write_reg = 3'd0;
        exmem_halt = 1'b0; mem_redirect = 1'b0;
        imem_stall = 1'b0; dmem_stall = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    // Checks all six combinational controls in one go.
    task automatic check_ctrl(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze},
              {26'd0, exp});
    endtask

    // control vectors: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze}
    localparam logic [5:0] C_NORMAL   = 6'b110000;
    localparam logic [5:0] C_REDIRECT = 6'b101110;
    localparam logic [5:0] C_HAZARD   = 6'b000100;
    localparam logic [5:0] C_IMEM     = 6'b001000;
    localparam logic [5:0] C_FREEZE   = 6'b000001;
    localparam logic [5:0] C_HALTF    = 6'b001100;
    localparam logic [5:0] C_RESET    = 6'b001110;

    logic fwd;

    initial begin
`ifdef PIPE_CTRL_FORWARD_EN
        fwd = 1'b1;
`else
        fwd = 1'b0;
`endif
        clear_inputs();
        rst = 1'b1;
        @(negedge clk); #1;
        check_ctrl("reset_comb", C_RESET);
        step();
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_stall_cnt", {16'd0, stall_cycles}, 32'd0);
        rst = 1'b0; #1;
        check_ctrl("idle_normal", C_NORMAL);

        // --- load-use ---
        idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_write_reg = 3'd3;
        id_rs = 3'd3; id_rs_vld = 1'b1; #1;
        check_ctrl("loaduse_stall", C_HAZARD);
        check("loaduse_cnt0", {16'd0, stall_cycles}, 32'd0);
        step();
        clear_inputs(); #1;
        check("loaduse_cnt1", {16'd0, stall_cycles}, 32'd1);
        check_ctrl("loaduse_after", C_NORMAL);

        // load-use pattern but rs not read: no stall
        idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_write_reg = 3'd3;
        id_rs = 3'd3; id_rs_vld = 1'b0; #1;
        check_ctrl("loaduse_novld", C_NORMAL);

        // --- redirect over hazard ---
        id_rs_vld = 1'b1; mem_redirect = 1'b1; #1;
        check_ctrl("redirect_over_haz", C_REDIRECT);
        step();
        clear_inputs(); #1;
        check("redirect_cnt", {16'd0, stall_cycles}, 32'd1);

        // --- imem stall, and halt beating hazard/imem ---
        imem_stall = 1'b1; #1;
        check_ctrl("imem_stall", C_IMEM);

        // --- data stall with held redirect ---
        do_reset();
        dmem_stall = 1'b1; mem_redirect = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_ctrl($sformatf("dstall_freeze%0d", i), C_FREEZE);
            step();
        end
        dmem_stall = 1'b0; #1;
        check_ctrl("dstall_release_redirect", C_REDIRECT);
        check("dstall_cnt", {16'd0, stall_cycles}, 32'd5);
        step();
        clear_inputs(); #1;
        check_ctrl("dstall_back_run", C_NORMAL);
        check("dstall_cnt_hold", {16'd0, stall_cycles}, 32'd5);

        // --- watchdog ---
        do_reset();
        dmem_stall = 1'b1;
        repeat (63) step();
        check("wd_err_63", {31'd0, err}, 32'd0);
        step();
        check("wd_err_64", {31'd0, err}, 32'd1);
        check("wd_cnt_64", {16'd0, stall_cycles}, 32'd64);
        dmem_stall = 1'b0;
        step();
        check("wd_err_sticky", {31'd0, err}, 32'd1);
        check_ctrl("wd_release", C_NORMAL);
        step();
        check("wd_err_sticky2", {31'd0, err}, 32'd1);

        // --- halt then reset ---
        do_reset();
        exmem_halt = 1'b1; imem_stall = 1'b1; #1;
        check_ctrl("halt_entry", C_HALTF);
        check("halt_entry_halted", {31'd0, halted}, 32'd0);
        step();
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            // memory inputs must not disturb HALT
            dmem_stall = i[0];
            mem_redirect = i[1];
            #1;
            check($sformatf("halt_halted%0d", i), {31'd0, halted}, 32'd1);
            check_ctrl($sformatf("halt_ctrl%0d", i), C_HALTF);
            step();
        end
        check("halt_cnt", {16'd0, stall_cycles}, 32'd1);
        dmem_stall = 1'b1;
        rst = 1'b1; #1;
        check_ctrl("halt_rst_comb", C_RESET);
        step();
        rst = 1'b0; clear_inputs(); #1;
        check("halt_rst_halted", {31'd0, halted}, 32'd0);
        check("halt_rst_cnt", {16'd0, stall_cycles}, 32'd0);
        check_ctrl("halt_rst_run", C_NORMAL);

        // --- EX/MEM RAW ---
        exmem_reg_write = 1'b1; exmem_write_reg = 3'd5; id_rt = 3'd5; id_rt_vld = 1'b1; #1;
        check_ctrl("exmem_raw", fwd ? C_NORMAL : C_HAZARD);
        exmem_write_reg = 3'd4; #1;
        check_ctrl("exmem_raw_nomatch", C_NORMAL);
        clear_inputs();

        // --- ID/EX RAW on a non-load ---
        idex_reg_write = 1'b1; idex_write_reg = 3'd2; id_rs = 3'd2; id_rs_vld = 1'b1; #1;
        check_ctrl("idex_raw_alu", fwd ? C_NORMAL : C_HAZARD);
        clear_inputs();

        // --- reset during DSTALL ---
        do_reset();
        dmem_stall = 1'b1;
        step(); step();
        rst = 1'b1; #1;
        check_ctrl("dstall_rst_comb", C_RESET);
        step();
        rst = 1'b0; dmem_stall = 1'b0; #1;
        check_ctrl("dstall_rst_run", C_NORMAL);
        check("dstall_rst_cnt", {16'd0, stall_cycles}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, on ports clk and rst.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs, id_rt  in  3 each  source registers of the instruction in ID
- id_rs_vld, id_rt_vld  in  1 each  source register is actually read
- idex_reg_write, idex_mem_read  in  1 each  ID/EX control bits
- idex_write_reg  in  3  ID/EX destination
- exmem_reg_write  in  1  EX/MEM write enable
- exmem_write_reg  in  3  EX/MEM destination
- exmem_halt  in  1  halt instruction in MEM
- mem_redirect  in  1  taken branch or jump resolved in MEM
- imem_stall, dmem_stall  in  1 each  memory not done this cycle
- pc_write, ifid_write  out  1 each  PC and IF/ID load enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all control bits 0)
- freeze  out  1  every pipeline register holds its value
- halted  out  1  processor stopped (sticky)
- stall_cycles  out  16  count of non-advancing cycles
- err  out  1  watchdog error (sticky)

Function
REQ-003 The FSM SHALL have three states: RUN, DSTALL and HALT.
REQ-004 In RUN, outputs SHALL be evaluated combinationally, with the first matching rule winning:
- (a) dmem_stall: freeze=1, pc_write=0, ifid_write=0; next state DSTALL.
- (b) mem_redirect: pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1.
- (c) exmem_halt: pc_write=0, ifid_flush=1, idex_flush=1; next state HALT.
- (d) data hazard (REQ-008): pc_write=0, ifid_write=0, idex_flush=1.
- (e) imem_stall: pc_write=0, ifid_flush=1.
- (f) otherwise: pc_write=1, ifid_write=1, all flushes 0, freeze 0.
REQ-005 In DSTALL, freeze SHALL remain 1 while dmem_stall=1. The first cycle with dmem_stall=0 SHALL apply rules (b)-(f) and return to RUN.
REQ-006 In HALT:
- halted=1, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1.
- The in-flight EX/MEM and MEM/WB contents SHALL drain normally.
- Only rst leaves this state.
REQ-007 When mem_redirect and dmem_stall are both 1, the freeze SHALL win and the redirect SHALL be applied on the cycle dmem_stall falls, because the redirect is held in the frozen EX/MEM register.
REQ-008 The data hazard condition SHALL be a match on either rs (with id_rs_vld) or rt (with id_rt_vld) against a qualifying destination.
- With forwarding, the only qualifying destination is idex_write_reg with idex_reg_write=1 and idex_mem_read=1 (load-use), so a load-use stall lasts exactly 1 cycle.
- Without forwarding, the qualifying destinations are idex_write_reg (idex_reg_write=1) and exmem_write_reg (exmem_reg_write=1).
- MEM/WB is never checked, because the register file writes before it reads.
REQ-009 stall_cycles SHALL increment by 1 on every cycle in which pc_write=0 and state is not HALT. It SHALL wrap from 0xFFFF to 0x0000.
REQ-010 A watchdog SHALL count consecutive DSTALL cycles.
- When the count reaches 64, err SHALL be set to 1.
- err stays 1 until rst.
- The count clears whenever the FSM leaves DSTALL.

Reset
REQ-011 While rst=1:
- state becomes RUN.
- halted, err, stall_cycles and the watchdog count clear to 0 on the clock edge.
- Combinational outputs SHALL be pc_write=0, ifid_write=0, all flushes=1, freeze=0.
REQ-012 A reset asserted during DSTALL or HALT SHALL take effect at the next edge, regardless of the memory inputs.

Configuration
REQ-013 When macro PIPE_CTRL_FORWARD_EN is defined, hazard detection SHALL be load-use only. When it is undefined, the full RAW check against ID/EX and EX/MEM SHALL apply. All other behaviour is identical either way.

Verification
REQ-014 The bench SHALL cover these directed scenarios:
- Load-use: idex_mem_read=1, idex_reg_write=1, idex_write_reg=3, id_rs=3, id_rs_vld=1 -> one cycle with pc_write=0 and idex_flush=1; stall_cycles goes 0->1.
- Redirect over hazard: the load-use condition above plus mem_redirect=1 -> pc_write=1 and ifid_flush, idex_flush, exmem_flush all 1.
- Data stall: dmem_stall=1 for 5 cycles with mem_redirect=1 -> freeze=1 for 5 cycles, then one cycle with the three flushes; stall_cycles=5.
- Watchdog: dmem_stall=1 for 64 cycles -> err=1 from cycle 64 onward; err stays 1 after dmem_stall drops.
- Halt then reset: exmem_halt=1 -> halted=1 and pc_write=0 held for 10 cycles; rst=1 for 1 cycle -> halted=0, stall_cycles=0.
- EX/MEM RAW: exmem_reg_write=1, exmem_write_reg=5, id_rt=5, id_rt_vld=1 -> stall with PIPE_CTRL_FORWARD_EN undefined; no stall with it defined.
